// File: rtl/intra_blk_scheduler_pkg.sv
// Shared types and constants for the intra 4x4 block scheduler.
// Holds the scheduler state encodings and the last-block index.
package intra_blk_scheduler_pkg;

  typedef enum logic [1:0] {
    intra_sched_idle_s      = 2'd0,
    intra_sched_wait_pred_s = 2'd1,
    intra_sched_wait_sum_s  = 2'd2
  } intra_sched_state_e;

  localparam logic [4:0] INTRA_SCHED_LAST_BLK = 5'd23;
  localparam int         INTRA_SCHED_WDOG_W   = 12;

  function automatic logic rising(
    input logic lvl,
    input logic lvl_q
  );
    return lvl & ~lvl_q;
  endfunction

endpackage

// File: rtl/intra_sched_watchdog.sv
// Stall watchdog for the intra block scheduler.
// Counts busy cycles since the last state change; flags the limit.
module intra_sched_watchdog
  import intra_blk_scheduler_pkg::*;
#(
  parameter int WDOG_CYCLES = 4095
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam logic [INTRA_SCHED_WDOG_W-1:0] LIMIT_M1 =
    INTRA_SCHED_WDOG_W'(WDOG_CYCLES - 1);

  logic [INTRA_SCHED_WDOG_W-1:0] cnt_q;
  logic [INTRA_SCHED_WDOG_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ena) begin
      cnt_q <= cnt_d;
    end
  end

  // Fires on the cycle whose increment would reach the limit,
  // so the flag lands exactly WDOG_CYCLES cycles after entry.
  assign expire = count_en & (cnt_q == LIMIT_M1);

endmodule

// File: rtl/intra_blk_scheduler.sv
// Sequences the 24 4x4 blocks of a macroblock through intra pred and recon.
// Optional stall watchdog and timeout_err port with INTRA_SCHED_WDOG_EN.
module intra_blk_scheduler
  import intra_blk_scheduler_pkg::*;
#(
  parameter int WDOG_CYCLES = 4095
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic       start_of_MB,
  input  logic       mb_pred_inter_sel,
  input  logic       pred_valid,
  input  logic       sum_valid,
  output logic [4:0] blk4x4_counter,
  output logic       pred_start,
  output logic       busy,
  output logic       mb_done
`ifdef INTRA_SCHED_WDOG_EN
  ,
  output logic       timeout_err
`endif
);

  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 4095) begin : g_bad_wdog
    $error("WDOG_CYCLES must be in 2..4095");
  end

  intra_sched_state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic       pred_start_q, pred_start_d;
  logic       busy_q, busy_d;
  logic       mb_done_q, mb_done_d;
  logic       sum_seen_q, sum_seen_d;
  logic       inter_q, inter_d;
  logic       pred_valid_s_q;
  logic       sum_valid_s_q;
  logic       pred_edge;
  logic       sum_edge;
  logic       sum_go;

`ifdef INTRA_SCHED_WDOG_EN
  logic timeout_q, timeout_d;
  logic wdog_expire;
  logic wdog_clear;
  logic wdog_count_en;
`endif

  assign pred_edge = rising(pred_valid, pred_valid_s_q);
  assign sum_edge  = rising(sum_valid, sum_valid_s_q);
  assign sum_go    = sum_edge | sum_seen_q;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pred_start_d = 1'b0;
    mb_done_d    = 1'b0;
    busy_d       = busy_q;
    sum_seen_d   = sum_seen_q;
    inter_d      = inter_q;
`ifdef INTRA_SCHED_WDOG_EN
    timeout_d    = timeout_q;
`endif
    if (start_of_MB) begin
      cnt_d        = 5'd0;
      busy_d       = 1'b1;
      sum_seen_d   = 1'b0;
      inter_d      = mb_pred_inter_sel;
      pred_start_d = ~mb_pred_inter_sel;
      state_d      = mb_pred_inter_sel ?
                     intra_sched_wait_sum_s :
                     intra_sched_wait_pred_s;
`ifdef INTRA_SCHED_WDOG_EN
      timeout_d    = 1'b0;
`endif
    end
`ifdef INTRA_SCHED_WDOG_EN
    else if (wdog_expire) begin
      timeout_d  = 1'b1;
      busy_d     = 1'b0;
      sum_seen_d = 1'b0;
      state_d    = intra_sched_idle_s;
    end
`endif
    else begin
      unique case (state_q)
        intra_sched_wait_pred_s: begin
          if (sum_edge) begin
            sum_seen_d = 1'b1;
          end
          if (pred_edge) begin
            state_d = intra_sched_wait_sum_s;
          end
        end
        intra_sched_wait_sum_s: begin
          if (sum_go) begin
            sum_seen_d = 1'b0;
            if (cnt_q == INTRA_SCHED_LAST_BLK) begin
              state_d   = intra_sched_idle_s;
              mb_done_d = 1'b1;
              busy_d    = 1'b0;
            end else begin
              cnt_d = cnt_q + 5'd1;
              if (!inter_q) begin
                state_d      = intra_sched_wait_pred_s;
                pred_start_d = 1'b1;
              end
            end
          end
        end
        default: begin
          state_d = intra_sched_idle_s;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= intra_sched_idle_s;
      cnt_q          <= 5'd0;
      pred_start_q   <= 1'b0;
      busy_q         <= 1'b0;
      mb_done_q      <= 1'b0;
      sum_seen_q     <= 1'b0;
      inter_q        <= 1'b0;
      pred_valid_s_q <= 1'b0;
      sum_valid_s_q  <= 1'b0;
`ifdef INTRA_SCHED_WDOG_EN
      timeout_q      <= 1'b0;
`endif
    end else if (ena) begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pred_start_q   <= pred_start_d;
      busy_q         <= busy_d;
      mb_done_q      <= mb_done_d;
      sum_seen_q     <= sum_seen_d;
      inter_q        <= inter_d;
      pred_valid_s_q <= pred_valid;
      sum_valid_s_q  <= sum_valid;
`ifdef INTRA_SCHED_WDOG_EN
      timeout_q      <= timeout_d;
`endif
    end
  end

`ifdef INTRA_SCHED_WDOG_EN
  // A restart into the same state must still rearm the counter.
  assign wdog_clear    = start_of_MB | (state_d != state_q);
  assign wdog_count_en = (state_q == intra_sched_wait_pred_s) |
                         (state_q == intra_sched_wait_sum_s);

  intra_sched_watchdog #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .clear   (wdog_clear),
    .count_en(wdog_count_en),
    .expire  (wdog_expire)
  );

  assign timeout_err = timeout_q;
`endif

  assign blk4x4_counter = cnt_q;
  assign pred_start     = pred_start_q;
  assign busy           = busy_q;
  assign mb_done        = mb_done_q;

endmodule
